reg_sel_sequencer: RTL
======================

Name: reg_sel_sequencer

Overview:
Upstream stage of the general-purpose register bank. Latches one instruction word from the bus into an internal IR, decodes the Ra/Rb/Rc fields, and steps through the T3–T5 register-transfer sequence for ALU instructions. On each step it drives the one-hot GRin/GRout vectors, BAout, and the Y/Z datapath strobes that the register bank and ALU consume. It is a reduced control unit for R-format and immediate-format ALU instructions only.

Parameters:
OPW, 5, opcode field width (IR[31:27])
R_LAST, 11, highest R-format opcode; R-format is opcodes 0..R_LAST
I_FIRST, 12, lowest immediate-format opcode
I_LAST, 14, highest immediate-format opcode; any other opcode is illegal

Ports:
clk  in  1  system clock, rising edge
clear  in  1  synchronous, active-low reset
start  in  1  begin an instruction; sampled only in IDLE
BusMuxOut  in  32  bus value; captured into IR when start is accepted
GRin  out  16  one-hot register write enable (bit n = Rn)
GRout  out  16  one-hot register read select
BAout  out  1  R0-reads-as-zero qualifier
Cout  out  1  drive C_sign_extended onto the bus
C_sign_extended  out  32  IR[18:0] sign-extended from bit 18
Yin  out  1  load Y register
Zin  out  1  load Z register
Zlowout  out  1  drive Z low word onto the bus
alu_op  out  OPW  IR[31:27]; valid while busy
busy  out  1  high in states T3, T4, T5
done  out  1  one-cycle pulse in state DONE
illegal  out  1  sticky; set on an unsupported opcode, cleared by the next accepted start or by clear

Behaviour:
- Fields: ra = IR[26:23], rb = IR[22:19], rc = IR[18:15], C = IR[18:0].
- Reset (clear = 0 at a rising edge): state goes to IDLE, IR = 0, illegal = 0. Every output is 0 (C_sign_extended = 0 and alu_op = 0 because IR = 0). Reset has priority over everything else and aborts any operation in progress, with no further strobes.
- States: IDLE, T3, T4, T5, DONE.
- IDLE → T3 when start = 1:
  - IR <= BusMuxOut.
  - illegal <= 0.
  - If the opcode is neither R-format nor immediate-format, go to DONE instead and set illegal = 1.
- T3: GRout[rb] = 1, Yin = 1. BAout = 1 only for immediate-format. Next state T4.
- T4: Zin = 1.
  - R-format: GRout[rc] = 1.
  - Immediate-format: Cout = 1 and GRout = 0.
  - Next state T5.
- T5: Zlowout = 1, GRin[ra] = 1. Next state DONE.
- DONE: done = 1, then return to IDLE. A new start is accepted at the earliest in the following IDLE cycle.
- Outputs are decoded combinationally from state and IR only (Moore). No dependency on start or BusMuxOut.
- Latency: the start edge is followed by 4 cycles (T3, T4, T5, DONE), so done is asserted in cycle 4 after acceptance. For an illegal opcode, done is asserted in cycle 1.
- start is ignored in every state except IDLE. A start held high across DONE is taken as a new start in the next IDLE cycle.
- Invariants:
  - GRin and GRout are each 0 or one-hot.
  - GRin and GRout are never both nonzero in the same cycle.
  - At most one bus driver (GRout, Cout, Zlowout) is active per cycle.
- ra = 0 is legal: GRin[0] is asserted and R0 is written.
- rb = 0 with BAout = 1: the register bank returns zero. This sequencer asserts GRout[0] normally in that case.

Test Plan:
- Reset, then hold clear = 0 for 2 cycles with start = 1 → all outputs 0, state IDLE, no strobes.
- start with BusMuxOut = 0x02918000 (add r5,r2,r3) → T3: GRout = 0x0004, Yin. T4: GRout = 0x0008, Zin, alu_op = 0. T5: GRin = 0x0020, Zlowout. DONE: done = 1, illegal = 0.
- start with BusMuxOut = 0x6387FFFF (op 12, r7, r0, C = 0x7FFFF) → T3: GRout = 0x0001, BAout = 1. T4: Cout = 1, C_sign_extended = 0xFFFFFFFF, GRout = 0. T5: GRin = 0x0080.
- start with BusMuxOut = 0xF8000000 (op 31) → next cycle DONE, done = 1, illegal = 1, no GRin/GRout/Yin/Zin. A following legal start clears illegal.
- Pulse start again during T4 of an add → ignored, sequence completes unchanged. Drive clear = 0 during T4 of another add → next cycle IDLE, GRin never asserted.
- Hold start = 1 continuously over two instructions → back-to-back sequences, done every 5th cycle, invariants checked every cycle.

Source files
------------

// File: rtl/reg_sel_sequencer.sv
// Register-select sequencer: latches an instruction word, decodes Ra/Rb/Rc and
// steps T3..T5 to drive register-bank select vectors and Y/Z datapath strobes.
module reg_sel_sequencer #(
    parameter int OPW     = 5,
    parameter int R_LAST  = 11,
    parameter int I_FIRST = 12,
    parameter int I_LAST  = 14
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      BusMuxOut,
    output logic [15:0]      GRin,
    output logic [15:0]      GRout,
    output logic             BAout,
    output logic             Cout,
    output logic [31:0]      C_sign_extended,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic [OPW-1:0]   alu_op,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    typedef enum logic [2:0] {IDLE, T3, T4, T5, DONE} state_t;

    localparam logic [OPW-1:0] R_LAST_C  = R_LAST[OPW-1:0];
    localparam logic [OPW-1:0] I_FIRST_C = I_FIRST[OPW-1:0];
    localparam logic [OPW-1:0] I_LAST_C  = I_LAST[OPW-1:0];

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_q, illegal_d;

    logic [OPW-1:0] bus_op;
    logic           bus_legal;
    logic           ir_is_imm;
    logic [15:0]    ra_oh, rb_oh, rc_oh;

    assign bus_op    = BusMuxOut[31 -: OPW];
    assign bus_legal = (bus_op <= R_LAST_C) || ((bus_op >= I_FIRST_C) && (bus_op <= I_LAST_C));
    // Only legal opcodes ever reach T3/T4, so range-checking the immediate window suffices.
    assign ir_is_imm = (alu_op >= I_FIRST_C) && (alu_op <= I_LAST_C);

    assign alu_op          = ir_q[31 -: OPW];
    assign C_sign_extended = {{13{ir_q[18]}}, ir_q[18:0]};
    assign illegal         = illegal_q;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_reg_dec
            assign ra_oh[gi] = (ir_q[26:23] == 4'(gi));
            assign rb_oh[gi] = (ir_q[22:19] == 4'(gi));
            assign rc_oh[gi] = (ir_q[18:15] == 4'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q   <= IDLE;
            ir_q      <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        GRin      = 16'd0;
        GRout     = 16'd0;
        BAout     = 1'b0;
        Cout      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        Zlowout   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ir_d      = BusMuxOut;
                    illegal_d = !bus_legal;
                    state_d   = bus_legal ? T3 : DONE;
                end
            end
            T3: begin
                busy    = 1'b1;
                GRout   = rb_oh;
                Yin     = 1'b1;
                BAout   = ir_is_imm;
                state_d = T4;
            end
            T4: begin
                busy = 1'b1;
                Zin  = 1'b1;
                // Immediate operand comes from C on the bus, so no register is read.
                if (ir_is_imm) begin
                    Cout = 1'b1;
                end else begin
                    GRout = rc_oh;
                end
                state_d = T5;
            end
            T5: begin
                busy    = 1'b1;
                Zlowout = 1'b1;
                GRin    = ra_oh;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
